mem_access_unit: RTL and testbench

- MEM-stage load/store unit between the EX/MEM pipeline register and the MEM/WB register.
- Converts a load/store from EX/MEM into a req/ack transaction on the data-memory port, and generates byte enables and store-data lane replication.
- Extracts and sign/zero-extends load data, which becomes i_rdata of MEM/WB.
- Stalls the pipeline for the duration of each access; flags misaligned and timed-out accesses.

---
 rtl/mem_access_unit.sv | 144 ++++++++++++++
 tb/tb_mem_access_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit. It turns an EX/MEM load or store into a req/ack
// transaction on the data-memory port, builds byte enables and replicated store
// lanes, extends the returned load data, and holds the pipeline while the
// access is in flight.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_wb_stall,
  output logic        o_stall,
  output logic [31:0] o_rdata,
  output logic        o_rdata_valid,
  output logic        o_misalign,
  output logic        o_timeout,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t                            state;
  logic [7:0]                        cnt;
  logic [29:0]                       waddr_q;
  logic                              we_q;
  logic [3:0]                        be_q;
  logic [NUM_LANES-1:0][VEC_W-1:0]   wdata_q;
  logic [2:0]                        f3_q;
  logic [1:0]                        off_q;
  logic [31:0]                       rdata_q;
  logic                              timeout_q;

  // funct3[1:0] selects the size; 011/110/111 all fall through to word
  logic is_b, is_h, is_w, acc, mis, start;
  assign is_b  = (i_funct3[1:0] == 2'b00);
  assign is_h  = (i_funct3[1:0] == 2'b01);
  assign is_w  = !is_b && !is_h;
  assign acc   = i_valid && (i_mem_read || i_mem_write);
  assign mis   = (is_h && i_addr[0]) || (is_w && (i_addr[1:0] != 2'b00));
  assign start = (state == IDLE) && acc && !mis;

  // Byte enables for the incoming access
  logic [3:0] be_n;
  always_comb begin
    be_n = 4'b1111;
    if (is_b)      be_n = 4'b0001 << i_addr[1:0];
    else if (is_h) be_n = 4'b0011 << i_addr[1:0];
  end

  // Store data replicated so every enabled byte lane carries the right byte
  logic [NUM_LANES-1:0][VEC_W-1:0] wdata_n;
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign wdata_n[l] = is_b ? i_wdata[VEC_W-1:0] :
                        is_h ? i_wdata[(l % 2)*VEC_W +: VEC_W] :
                               i_wdata[l*VEC_W +: VEC_W];
  end

  // Align the returned word to the access offset and extend by size/sign
  logic [31:0] sh, ext;
  always_comb begin
    sh = i_dmem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ext = {{24{sh[7]}},  sh[7:0]};
      3'b100:  ext = {24'd0,        sh[7:0]};
      3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
      3'b101:  ext = {16'd0,        sh[15:0]};
      default: ext = sh;
    endcase
  end

  // Access FSM: latch the request, wait for ack or timeout, hold result for WB
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      waddr_q   <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: if (start) begin
          waddr_q <= i_addr[31:2];
          we_q    <= i_mem_write;
          be_q    <= be_n;
          wdata_q <= wdata_n;
          f3_q    <= i_funct3;
          off_q   <= i_addr[1:0];
          cnt     <= '0;
          rdata_q <= '0;
          state   <= REQ;
        end
        REQ: begin
          if (i_dmem_ack) begin
            rdata_q <= we_q ? 32'd0 : ext;
            state   <= DONE;
          end else if (cnt == TO_LAST) begin
            timeout_q <= 1'b1;
            rdata_q   <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: if (!i_wb_stall) begin
          rdata_q <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational outputs are forced low while reset is held
  assign o_stall       = i_reset && (start || (state == REQ));
  assign o_misalign    = i_reset && (state == IDLE) && acc && mis;
  assign o_rdata       = rdata_q;
  assign o_rdata_valid = (state == DONE);
  assign o_timeout     = timeout_q;
  assign o_dmem_req    = (state == REQ);
  assign o_dmem_we     = o_dmem_req && we_q;
  assign o_dmem_be     = o_dmem_req ? be_q : 4'b0000;
  assign o_dmem_addr   = {waddr_q, 2'b00};
  assign o_dmem_wdata  = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded bench for mem_access_unit: a driver issues loads/stores and
// pushes the expected outcome; a monitor pops and compares on each completion.
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        i_clk = 1'b0, i_reset = 1'b0;
  logic        i_valid = 0, i_mem_read = 0, i_mem_write = 0, i_wb_stall = 0;
  logic [2:0]  i_funct3 = 0;
  logic [31:0] i_addr = 0, i_wdata = 0, i_dmem_rdata = 0;
  logic        i_dmem_ack = 0;
  logic        o_stall, o_rdata_valid, o_misalign, o_timeout, o_dmem_req, o_dmem_we;
  logic [31:0] o_rdata, o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_wb_stall(i_wb_stall), .o_stall(o_stall), .o_rdata(o_rdata),
    .o_rdata_valid(o_rdata_valid), .o_misalign(o_misalign), .o_timeout(o_timeout),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata), .i_dmem_ack(i_dmem_ack),
    .i_dmem_rdata(i_dmem_rdata));

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          mis;
    bit          to;
    logic [31:0] rdata, addr, wdata;
    logic [3:0]  be;
    logic        we;
    int          stalls, reqs;
  } exp_t;

  exp_t q[$];
  int   nchk = 0, nerr = 0;
  int   cur_waits = 0, wbs_left = 0;
  logic [31:0] cur_mem = 0;
  bit   mon_skip = 0, force_ack = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: load value from the word, by size and signedness
  function automatic logic [31:0] load_val(input logic [31:0] mem, input int off,
                                           input logic [2:0] f3);
    logic [31:0] w;
    int v;
    w = mem >> (8 * off);
    case (f3)
      3'd0: begin v = int'(w & 32'hFF);   if (v >= 128)   v -= 256;   return 32'(v); end
      3'd1: begin v = int'(w & 32'hFFFF); if (v >= 32768) v -= 65536; return 32'(v); end
      3'd4: return w & 32'hFF;
      3'd5: return w & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  // Memory responder: acks after cur_waits wait cycles; noise acks while idle
  initial forever begin
    int wc;
    @(negedge i_clk); #1;
    if (force_ack) begin
      i_dmem_ack = 1; i_dmem_rdata = $urandom;
    end else if (o_dmem_req) begin
      if (wc < cur_waits) begin i_dmem_ack = 0; wc++; end
      else begin i_dmem_ack = 1; i_dmem_rdata = cur_mem; end
    end else begin
      wc = 0;
      i_dmem_ack = ($urandom % 4 == 0);
      i_dmem_rdata = $urandom;
    end
  end

  // Monitor: accumulate per-access observations, compare at completion
  initial begin
    int st_cnt, req_cnt;
    bit prev_v, stable;
    logic [31:0] a0, w0, held;
    logic [3:0] b0;
    logic we0;
    exp_t e;
    st_cnt = 0; req_cnt = 0; prev_v = 0; stable = 1; held = 0;
    a0 = 0; w0 = 0; b0 = 0; we0 = 0;
    forever begin
      @(negedge i_clk); #2;
      if (!i_reset || mon_skip) begin
        st_cnt = 0; req_cnt = 0; prev_v = 0; stable = 1;
      end else begin
        if (o_stall) st_cnt++;
        if (o_dmem_req) begin
          if (req_cnt == 0) begin
            a0 = o_dmem_addr; b0 = o_dmem_be; we0 = o_dmem_we; w0 = o_dmem_wdata;
          end else if (a0 !== o_dmem_addr || b0 !== o_dmem_be || we0 !== o_dmem_we ||
                       w0 !== o_dmem_wdata) stable = 0;
          req_cnt++;
        end
        if (o_misalign) begin
          if (q.size() == 0) chk("unexpected_misalign", 1, 0);
          else begin
            e = q.pop_front();
            chk("misalign_expected", 1, 32'(e.mis));
            chk("misalign_stall", 32'(o_stall), 0);
            chk("misalign_req", 32'(o_dmem_req), 0);
            chk("misalign_rdata", o_rdata, 0);
          end
          st_cnt = 0; req_cnt = 0; stable = 1;
        end
        if (o_rdata_valid && !prev_v) begin
          if (q.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            e = q.pop_front();
            chk("done_not_misalign", 32'(e.mis), 0);
            chk("rdata", o_rdata, e.rdata);
            chk("timeout_pulse", 32'(o_timeout), 32'(e.to));
            chk("req_cycles", 32'(req_cnt), 32'(e.reqs));
            chk("stall_cycles", 32'(st_cnt), 32'(e.stalls));
            chk("dmem_addr", a0, e.addr);
            chk("dmem_be", 32'(b0), 32'(e.be));
            chk("dmem_we", 32'(we0), 32'(e.we));
            chk("dmem_wdata", w0, e.wdata);
            chk("req_stable", 32'(stable), 1);
            held = e.rdata;
          end
          st_cnt = 0; req_cnt = 0; stable = 1;
        end else if (o_rdata_valid && prev_v) begin
          chk("held_rdata", o_rdata, held);
          chk("held_no_req", 32'(o_dmem_req), 0);
          chk("held_no_timeout", 32'(o_timeout), 0);
        end
        prev_v = o_rdata_valid;
      end
    end
  end

  // Issue one access (caller is at a negedge); hold it until it retires
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] mem, input int waits, input int wbs);
    exp_t e;
    int sz, off, cyc;
    bit wb, retire;
    sz  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    off = int'(addr[1:0]);
    e.mis = (addr % sz) != 0;
    e.to = 0; e.rdata = 0; e.addr = 0; e.wdata = 0; e.be = 0; e.we = 0;
    e.stalls = 0; e.reqs = 0;
    if (!e.mis) begin
      e.to     = (waits >= TO);
      e.reqs   = e.to ? TO : waits + 1;
      e.stalls = 1 + e.reqs;
      e.addr   = addr & ~32'd3;
      e.we     = wr;
      e.be     = 4'(((1 << sz) - 1) << off);
      e.wdata  = (sz == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                 (sz == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
      e.rdata  = (e.to || wr) ? 32'd0 : load_val(mem, off, f3);
    end
    q.push_back(e);
    cur_waits = waits; cur_mem = mem; wbs_left = wbs;
    i_valid = 1; i_mem_read = rd; i_mem_write = wr; i_funct3 = f3;
    i_addr = addr; i_wdata = wd;
    cyc = 0;
    retire = 0;
    while (!retire && cyc < 40) begin
      #1;
      wb = o_rdata_valid && (wbs_left > 0);
      if (wb) wbs_left--;
      i_wb_stall = wb;
      retire = !o_stall && !wb;
      @(negedge i_clk);
      cyc++;
    end
    if (!retire) chk("retire_budget", 0, 1);
    i_wb_stall = 0;
    i_valid = 0; i_mem_read = 0; i_mem_write = 0;
  endtask

  // Non-access cycles: pipeline bubbles or non-memory instructions
  task automatic bubbles(input int n);
    for (int k = 0; k < n; k++) begin
      i_valid = $urandom % 2; i_mem_read = 0; i_mem_write = 0;
      i_funct3 = 3'($urandom); i_addr = $urandom; i_wdata = $urandom;
      #1;
      chk("bubble_stall", 32'(o_stall), 0);
      chk("bubble_misalign", 32'(o_misalign), 0);
      @(negedge i_clk);
    end
    i_valid = 0;
  endtask

  initial begin
    logic [2:0] f3tab [8];
    f3tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    // Reset held with a live aligned access on the inputs
    i_valid = 1; i_mem_read = 1; i_funct3 = 3'd2; i_addr = 32'h100;
    #22;
    chk("rst_stall", 32'(o_stall), 0);
    chk("rst_req", 32'(o_dmem_req), 0);
    chk("rst_valid", 32'(o_rdata_valid), 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_be", 32'(o_dmem_be), 0);
    chk("rst_timeout", 32'(o_timeout), 0);
    chk("rst_addr", o_dmem_addr, 0);
    i_valid = 0; i_mem_read = 0;
    @(negedge i_clk); i_reset = 1;
    @(negedge i_clk);

    // Directed cases
    do_access(1, 0, 3'd0, 32'h1003, 0, 32'h80FF_0000, 0, 0);       // LB zero-wait
    bubbles(1);
    do_access(0, 1, 3'd1, 32'h2002, 32'h1234_ABCD, 0, 3, 0);       // SH 3 waits
    bubbles(1);
    do_access(1, 0, 3'd2, 32'h0006, 0, 32'hDEAD_BEEF, 0, 0);       // LW misaligned
    do_access(1, 0, 3'd5, 32'h0006, 0, 32'hBEEF_0000, 0, 0);       // LHU
    bubbles(1);
    do_access(1, 0, 3'd2, 32'h0100, 0, 32'h1111_2222, 20, 0);      // timeout
    bubbles(1);
    do_access(1, 0, 3'd2, 32'h0200, 0, 32'hCAFE_F00D, 1, 2);       // WB hold
    bubbles(2);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      logic rd;
      logic [2:0] f3;
      logic [31:0] a;
      rd = 1'($urandom);
      f3 = rd ? f3tab[$urandom % 8] : 3'($urandom % 3);
      a = $urandom;
      if ($urandom % 4 != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        else if (f3[1:0] != 2'b00) a[1:0] = 2'b00;
      end
      do_access(rd, !rd, f3, a, $urandom, $urandom, $urandom_range(0, 5),
                ($urandom % 4 == 0) ? $urandom_range(1, 3) : 0);
      bubbles($urandom_range(0, 2));
    end

    // Reset in the middle of REQ, then a late ack
    mon_skip = 1;
    cur_waits = 1000;
    i_valid = 1; i_mem_read = 1; i_funct3 = 3'd2; i_addr = 32'h40;
    @(negedge i_clk); @(negedge i_clk);
    chk("pre_reset_req", 32'(o_dmem_req), 1);
    #3 i_reset = 0;
    #1;
    chk("midrst_req", 32'(o_dmem_req), 0);
    chk("midrst_stall", 32'(o_stall), 0);
    chk("midrst_be", 32'(o_dmem_be), 0);
    chk("midrst_we", 32'(o_dmem_we), 0);
    chk("midrst_valid", 32'(o_rdata_valid), 0);
    chk("midrst_wdata", o_dmem_wdata, 0);
    force_ack = 1;
    i_valid = 0; i_mem_read = 0;
    @(negedge i_clk); i_reset = 1;
    @(negedge i_clk); #3;
    chk("postrst_req", 32'(o_dmem_req), 0);
    chk("postrst_valid", 32'(o_rdata_valid), 0);
    force_ack = 0;
    @(negedge i_clk);
    mon_skip = 0;
    @(negedge i_clk);
    do_access(1, 0, 3'd4, 32'h3001, 0, 32'h0000_9A00, 0, 0);       // LBU after reset
    bubbles(3);

    chk("scoreboard_empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
